// File: rtl/glcd_pkg.sv
// rtl/glcd_pkg.sv - shared constants and state types for the graphic LCD refresh controller
package glcd_pkg;

    // KS0108 instruction bytes
    localparam logic [7:0] CMD_DISP_OFF = 8'h3E;
    localparam logic [7:0] CMD_DISP_ON  = 8'h3F;
    localparam logic [7:0] CMD_START    = 8'hC0;
    localparam logic [7:0] CMD_PAGE     = 8'hB8;
    localparam logic [7:0] CMD_YADDR    = 8'h40;

    // Geometry of one controller chip
    localparam int PANEL_COLS  = 64;
    localparam int PANEL_PAGES = 8;

    typedef enum logic [3:0] {
        S_POR_LO,
        S_POR_HI,
        S_INIT_DISP,
        S_INIT_START,
        S_IDLE,
        S_PAGE,
        S_YADDR,
        S_FETCH,
        S_DATA,
        S_DISP
    } state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_E_HI,
        WR_E_LO
    } wr_state_t;

endpackage

// File: rtl/glcd_refresh_ctrl_bus_wr.sv
// rtl/glcd_refresh_ctrl_bus_wr.sv - one LCD bus write: SETUP, E_HI, E_LO
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a write; SETUP is the following cycle
//   rs, data, cs      write attributes, sampled during the SETUP cycle
//   done              high in the last E_LO cycle; a new start may coincide
//   lcd_e/rs/data/cs  panel bus signals
module glcd_bus_wr
    import glcd_pkg::*;
#(
    parameter int NUM_CHIPS = 2,
    parameter int E_CYCLES  = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rs,
    input  logic [7:0]           data,
    input  logic [NUM_CHIPS-1:0] cs,
    output logic                 done,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic [7:0]           lcd_data,
    output logic [NUM_CHIPS-1:0] lcd_cs
);

    localparam int EW = $clog2(E_CYCLES + 1);
    localparam logic [EW-1:0] E_LAST = EW'(E_CYCLES - 1);

    wr_state_t            st, st_nxt;
    logic [EW-1:0]        cnt;
    logic                 rs_q;
    logic [7:0]           data_q;
    logic [NUM_CHIPS-1:0] cs_q;
    logic                 setup_ph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= WR_IDLE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            cs_q   <= '0;
        end else begin
            st <= st_nxt;
            if (st == WR_E_HI || st == WR_E_LO)
                cnt <= (cnt == E_LAST) ? '0 : cnt + EW'(1);
            else
                cnt <= '0;
            // Data byte comes from a synchronous RAM whose output is only
            // valid in the SETUP cycle, so capture here rather than at start.
            if (setup_ph) begin
                rs_q   <= rs;
                data_q <= data;
                cs_q   <= cs;
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            WR_IDLE:  if (start) st_nxt = WR_SETUP;
            WR_SETUP: st_nxt = WR_E_HI;
            WR_E_HI:  if (cnt == E_LAST) st_nxt = WR_E_LO;
            WR_E_LO:  if (cnt == E_LAST) st_nxt = start ? WR_SETUP : WR_IDLE;
            default:  st_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        setup_ph = (st == WR_SETUP);
        done     = (st == WR_E_LO) && (cnt == E_LAST);
        lcd_e    = (st == WR_E_HI);
        lcd_rs   = setup_ph ? rs   : rs_q;
        lcd_data = setup_ph ? data : data_q;
        lcd_cs   = setup_ph ? cs   : cs_q;
    end

endmodule

// File: rtl/glcd_refresh_ctrl.sv
// rtl/glcd_refresh_ctrl.sv - KS0108-class LCD refresh controller: POR, init, framebuffer streaming
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   frame_start, auto_refresh  frame requests (sampled in IDLE only)
//   disp_en                    display on/off level, applied at init and frame end
//   fb_addr, fb_rd, fb_data    synchronous-read framebuffer port {chip,page,col}
//   busy, frame_done           status
//   lcd_*                      panel bus
module glcd_refresh_ctrl
    import glcd_pkg::*;
#(
    parameter int NUM_CHIPS  = 2,
    parameter int E_CYCLES   = 128,
    parameter int POR_CYCLES = 4096,
    parameter int START_LINE = 0,
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 auto_refresh,
    input  logic                 disp_en,
    output logic [CW+8:0]        fb_addr,
    output logic                 fb_rd,
    input  logic [7:0]           fb_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic [NUM_CHIPS-1:0] lcd_cs,
    output logic                 lcd_rst_n,
    output logic [7:0]           lcd_data
);

    localparam int PMAX = (E_CYCLES > POR_CYCLES) ? E_CYCLES : POR_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [PW-1:0] POR_LAST  = PW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] CHIP_LAST = CW'(NUM_CHIPS - 1);
    localparam logic [5:0]    COL_LAST  = 6'(PANEL_COLS - 1);
    localparam logic [2:0]    PAGE_LAST = 3'(PANEL_PAGES - 1);

    state_t               state, state_nxt;
    logic [PW-1:0]        por_cnt;
    logic [5:0]           col;
    logic [2:0]           page;
    logic [CW-1:0]        chip;
    logic                 disp_q;
    logic                 rst_q;
    logic                 wr_start, wr_done, wr_rs;
    logic [7:0]           wr_data;
    logic [NUM_CHIPS-1:0] wr_cs;
    logic                 last_byte;

    assign last_byte = (col == COL_LAST) && (page == PAGE_LAST) && (chip == CHIP_LAST);

    glcd_bus_wr #(
        .NUM_CHIPS (NUM_CHIPS),
        .E_CYCLES  (E_CYCLES)
    ) u_bus_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .cs       (wr_cs),
        .done     (wr_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .lcd_cs   (lcd_cs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_POR_LO;
        else        state <= state_nxt;
    end

    // A write is launched on the cycle that enters its state, so the bus
    // SETUP cycle coincides with the first cycle of that state.
    always_comb begin
        state_nxt = state;
        wr_start  = 1'b0;
        case (state)
            S_POR_LO: if (por_cnt == POR_LAST) state_nxt = S_POR_HI;
            S_POR_HI: if (por_cnt == POR_LAST) begin
                state_nxt = S_INIT_DISP;
                wr_start  = 1'b1;
            end
            S_INIT_DISP: if (wr_done) begin
                state_nxt = S_INIT_START;
                wr_start  = 1'b1;
            end
            S_INIT_START: if (wr_done) state_nxt = S_IDLE;
            S_IDLE: if (frame_start || auto_refresh) begin
                state_nxt = S_PAGE;
                wr_start  = 1'b1;
            end
            S_PAGE: if (wr_done) begin
                state_nxt = S_YADDR;
                wr_start  = 1'b1;
            end
            S_YADDR: if (wr_done) state_nxt = S_FETCH;
            S_FETCH: begin
                state_nxt = S_DATA;
                wr_start  = 1'b1;
            end
            S_DATA: if (wr_done) begin
                if (!last_byte) begin
                    if (col != COL_LAST) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_PAGE;
                        wr_start  = 1'b1;
                    end
                end else if (disp_q != disp_en) begin
                    state_nxt = S_DISP;
                    wr_start  = 1'b1;
                end else if (auto_refresh) begin
                    state_nxt = S_PAGE;
                    wr_start  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DISP: if (wr_done) begin
                if (auto_refresh) begin
                    state_nxt = S_PAGE;
                    wr_start  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_POR_LO;
        endcase
    end

    always_comb begin
        fb_rd      = (state == S_FETCH);
        busy       = (state != S_IDLE);
        frame_done = (state == S_DATA) && wr_done && last_byte;
        wr_rs      = (state == S_DATA);
        wr_cs      = NUM_CHIPS'(1) << chip;
        wr_data    = 8'h00;
        case (state)
            S_INIT_DISP, S_DISP: begin
                wr_data = disp_q ? CMD_DISP_ON : CMD_DISP_OFF;
                wr_cs   = '1;
            end
            S_INIT_START: begin
                wr_data = CMD_START | {2'b00, 6'(START_LINE)};
                wr_cs   = '1;
            end
            S_PAGE:  wr_data = CMD_PAGE | {5'b00000, page};
            S_YADDR: wr_data = CMD_YADDR;
            S_DATA:  wr_data = fb_data;
            default: wr_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            por_cnt <= '0;
            col     <= '0;
            page    <= '0;
            chip    <= '0;
            disp_q  <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            if (state == S_POR_LO || state == S_POR_HI)
                por_cnt <= (por_cnt == POR_LAST) ? '0 : por_cnt + PW'(1);
            else
                por_cnt <= '0;
            if (state == S_DATA && wr_done) begin
                col <= col + 6'd1;
                if (col == COL_LAST) begin
                    page <= page + 3'd1;
                    if (page == PAGE_LAST)
                        chip <= (chip == CHIP_LAST) ? '0 : chip + CW'(1);
                end
            end
            if (wr_start && (state_nxt == S_INIT_DISP || state_nxt == S_DISP))
                disp_q <= disp_en;
            rst_q <= (state_nxt != S_POR_LO);
        end
    end

    assign fb_addr   = {chip, page, col};
    assign lcd_rw    = 1'b0;
    assign lcd_rst_n = rst_q;

endmodule

// File: tb/tb_glcd_refresh_ctrl.sv
// tb/tb_glcd_refresh_ctrl.sv - scoreboard bench for glcd_refresh_ctrl
module tb_glcd_refresh_ctrl;

    localparam int NUM_CHIPS  = 2;
    localparam int E_CYCLES   = 2;
    localparam int POR_CYCLES = 8;
    localparam int CW         = 1;

    typedef logic [NUM_CHIPS+9:0] wr_t;  // {rw, cs, rs, data}

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 frame_start, auto_refresh, disp_en;
    logic [CW+8:0]        fb_addr;
    logic                 fb_rd;
    logic [7:0]           fb_data = 8'h00;
    logic                 busy, frame_done;
    logic                 lcd_e, lcd_rs, lcd_rw, lcd_rst_n;
    logic [NUM_CHIPS-1:0] lcd_cs;
    logic [7:0]           lcd_data;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t expq[$];

    glcd_refresh_ctrl #(
        .NUM_CHIPS  (NUM_CHIPS),
        .E_CYCLES   (E_CYCLES),
        .POR_CYCLES (POR_CYCLES),
        .START_LINE (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .auto_refresh (auto_refresh),
        .disp_en      (disp_en),
        .fb_addr      (fb_addr),
        .fb_rd        (fb_rd),
        .fb_data      (fb_data),
        .busy         (busy),
        .frame_done   (frame_done),
        .lcd_e        (lcd_e),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_cs       (lcd_cs),
        .lcd_rst_n    (lcd_rst_n),
        .lcd_data     (lcd_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read framebuffer: byte = address[7:0]
    always @(posedge clk) if (fb_rd) fb_data <= fb_addr[7:0];

    // Bus monitor: every rising E is one write, compared against the queue.
    logic prev_e = 1'b0;
    int   hi_len = 0;
    wr_t  cap;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0;
            hi_len = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                hi_len = 1;
                cap = {lcd_rw, lcd_cs, lcd_rs, lcd_data};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write got=%h required=none", cap);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    if (cap !== e) begin
                        miscompares++;
                        $display("FAIL write got=%h required=%h", cap, e);
                    end
                end
            end else if (lcd_e && prev_e) begin
                hi_len++;
                vectors++;
                if ({lcd_rw, lcd_cs, lcd_rs, lcd_data} !== cap) begin
                    miscompares++;
                    $display("FAIL bus_stable got=%h required=%h", {lcd_rw, lcd_cs, lcd_rs, lcd_data}, cap);
                end
            end else if (!lcd_e && prev_e) begin
                vectors++;
                if (hi_len != E_CYCLES) begin
                    miscompares++;
                    $display("FAIL e_high_len got=%0d required=%0d", hi_len, E_CYCLES);
                end
            end
            prev_e = lcd_e;
        end
    end

    task automatic push_frame();
        logic [NUM_CHIPS-1:0] cs1;
        for (int c = 0; c < NUM_CHIPS; c++) begin
            cs1 = NUM_CHIPS'(1) << c;
            for (int p = 0; p < 8; p++) begin
                expq.push_back({1'b0, cs1, 1'b0, 8'hB8 | 8'(p)});
                expq.push_back({1'b0, cs1, 1'b0, 8'h40});
                for (int k = 0; k < 64; k++)
                    expq.push_back({1'b0, cs1, 1'b1, 8'((c << 9) | (p << 6) | k)});
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_cs, lcd_rst_n, lcd_data, fb_rd, fb_addr, busy, frame_done}
            !== {1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 10'h000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got e=%b rs=%b rw=%b cs=%b rst_n=%b data=%h fb_rd=%b fb_addr=%h busy=%b done=%b required busy=1 others 0",
                     lcd_e, lcd_rs, lcd_rw, lcd_cs, lcd_rst_n, lcd_data, fb_rd, fb_addr, busy, frame_done);
        end
    endtask

    task automatic test_power_on();
        int n;
        disp_en = 1'b1;
        expq.push_back({1'b0, 2'b11, 1'b0, 8'h3F});
        expq.push_back({1'b0, 2'b11, 1'b0, 8'hC0});
        rst_n = 1'b1;
        n = 0;
        while (!lcd_rst_n && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (n != POR_CYCLES) begin
            miscompares++;
            $display("FAIL por_low_cycles got=%0d required=%0d", n, POR_CYCLES);
        end
        n = 0;
        while (lcd_cs == '0 && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (n != POR_CYCLES) begin
            miscompares++;
            $display("FAIL por_high_cycles got=%0d required=%0d", n, POR_CYCLES);
        end
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (n != 2 * (1 + 2 * E_CYCLES)) begin
            miscompares++;
            $display("FAIL init_to_idle got=%0d required=%0d", n, 2 * (1 + 2 * E_CYCLES));
        end
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL init_writes_pending got=%0d required=0", expq.size());
        end
    endtask

    task automatic test_frame();
        int k;
        push_frame();
        frame_start = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; frame_start = 1'b0; end while (!frame_done && k < 10000);
        vectors++;
        if (k != 6304) begin
            miscompares++;
            $display("FAIL frame_len got=%0d required=6304", k);
        end
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL frame_writes_pending got=%0d required=0", expq.size());
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_frame got=%b required=0", busy);
        end
    endtask

    task automatic test_ignore_start();
        int k, extra;
        push_frame();
        frame_start = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; frame_start = (k == 2000); end while (!frame_done && k < 10000);
        frame_start = 1'b0;
        vectors++;
        if (k != 6304) begin
            miscompares++;
            $display("FAIL ignore_frame_len got=%0d required=6304", k);
        end
        extra = 0;
        repeat (40) begin @(negedge clk); if (frame_done || busy) extra++; end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignored_start_ran got=%0d busy_cycles required=0", extra);
        end
    endtask

    task automatic test_auto_refresh();
        int k;
        push_frame();
        push_frame();
        auto_refresh = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!frame_done && k < 10000);
        vectors++;
        if (k != 6304) begin
            miscompares++;
            $display("FAIL auto_first_len got=%0d required=6304", k);
        end
        @(negedge clk);
        vectors++;
        if ({lcd_cs, lcd_rs, lcd_data, lcd_e, busy} !== {2'b01, 1'b0, 8'hB8, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL auto_restart_setup got cs=%b rs=%b data=%h e=%b busy=%b required cs=01 rs=0 data=b8 e=0 busy=1",
                     lcd_cs, lcd_rs, lcd_data, lcd_e, busy);
        end
        auto_refresh = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!frame_done && k < 10000);
        vectors++;
        if (k != 6303) begin
            miscompares++;
            $display("FAIL auto_second_len got=%0d required=6303", k);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL auto_stop got busy=%b pending=%0d required busy=0 pending=0", busy, expq.size());
        end
    endtask

    task automatic test_disp_update();
        int k, n;
        push_frame();
        frame_start = 1'b1;
        k = 0;
        do begin
            @(negedge clk); k++; frame_start = 1'b0;
            if (k == 3000) begin
                disp_en = 1'b0;
                expq.push_back({1'b0, 2'b11, 1'b0, 8'h3E});
            end
        end while (!frame_done && k < 10000);
        vectors++;
        if (k != 6304) begin
            miscompares++;
            $display("FAIL disp_frame_len got=%0d required=6304", k);
        end
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (n != 2 + 2 * E_CYCLES) begin
            miscompares++;
            $display("FAIL disp_update_len got=%0d required=%0d", n, 2 + 2 * E_CYCLES);
        end
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL disp_write_missing got=%0d pending required=0", expq.size());
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        push_frame();
        frame_start = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; frame_start = 1'b0; end while (!(lcd_e && lcd_rs) && k < 2000);
        vectors++;
        if (!(lcd_e && lcd_rs)) begin
            miscompares++;
            $display("FAIL data_e_hi_timeout got=%0d cycles required=data write", k);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({lcd_e, lcd_rst_n, lcd_cs, busy, fb_rd, frame_done} !== {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got e=%b rst_n=%b cs=%b busy=%b fb_rd=%b done=%b required 0 0 00 1 0 0",
                     lcd_e, lcd_rst_n, lcd_cs, busy, fb_rd, frame_done);
        end
        expq.delete();
        repeat (3) @(negedge clk);
        test_power_on();
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_start  = 1'b0;
        auto_refresh = 1'b0;
        disp_en      = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_power_on();
        test_frame();
        test_ignore_start();
        test_auto_refresh();
        test_disp_update();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/glcd_refresh_ctrl.md
# glcd_refresh_ctrl

Parametrised KS0108-class graphic LCD refresh controller. It owns the panel's bus (E, RS, RW, per-chip CS, reset, data). It sequences the power-on reset and the init commands, then streams a full frame from an external framebuffer to the panel, page by page and column by column. It replaces the hand-sequenced draw logic in the game top level: game logic writes a framebuffer, and this block handles every LCD bus transaction.

## Interface
Parameters:
- NUM_CHIPS, 2: controller chips on the panel, 1–4; each chip drives 64 columns × 8 pages.
- E_CYCLES, 128: clk cycles per E-high phase and per E-low phase, ≥1.
- POR_CYCLES, 4096: clk cycles lcd_rst_n is held low after reset, and again high before the first command, ≥1.
- START_LINE, 0: display start line written at init, 0–63.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle request to refresh one frame.
- auto_refresh  in  1  when 1, a new frame starts immediately after each frame_done.
- disp_en  in  1  panel display on/off level; a change is sent at the next frame boundary.
- fb_addr  out  CW+9  framebuffer byte address {chip, page[2:0], col[5:0]}; CW = max(1,$clog2(NUM_CHIPS)).
- fb_rd  out  1  framebuffer read strobe; fb_data is valid on the cycle after fb_rd.
- fb_data  in  8  framebuffer byte; bit 0 is the top row of the page.
- busy  out  1  high from reset release until IDLE, and during every frame.
- frame_done  out  1  one-cycle pulse when the last data byte's E-low phase ends.
- lcd_e, lcd_rs, lcd_rw  out  1 each  panel strobe, data/instruction select, read/write (lcd_rw is always 0).
- lcd_cs  out  NUM_CHIPS  active-high chip selects.
- lcd_rst_n  out  1  panel reset, active-low.
- lcd_data  out  8  panel data bus.

## Operation
- Write transaction (WR), NUM_CHIPS-agnostic:
  - SETUP (1 cycle): lcd_rs, lcd_data and lcd_cs are driven and lcd_e=0.
  - E_HI (E_CYCLES cycles): lcd_e=1.
  - E_LO (E_CYCLES cycles): lcd_e=0.
  - lcd_rs, lcd_data and lcd_cs stay stable through the whole transaction.
- States:
  - POR_LO: lcd_rst_n=0 for POR_CYCLES, then go to POR_HI.
  - POR_HI: lcd_rst_n=1 for POR_CYCLES, then go to INIT.
  - INIT: broadcast (all CS high) WR 0x3E|disp_en, then WR 0xC0|START_LINE, then go to IDLE.
  - IDLE: wait for frame_start, or auto_refresh.
  - FRAME: for chip 0..NUM_CHIPS-1, for page 0..7:
    - WR 0xB8|page, then WR 0x40, with only that chip's CS high.
    - Then for col 0..63: FETCH (1 cycle, fb_rd=1, fb_addr driven), then WR with RS=1 and data = fb_data captured on the cycle after FETCH.
- Frame end: pulse frame_done.
  - If the latched disp_en differs from the current input, broadcast WR 0x3E|disp_en and update the latch before returning to IDLE.
  - Then go to IDLE, or straight back to FRAME if auto_refresh=1.
- Counter widths: col 6 bits, page 3 bits, chip CW bits, phase counter $clog2(max(E_CYCLES,POR_CYCLES)+1) bits. All counters wrap to 0 at their terminal value.

## Timing
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_cs=0, lcd_rst_n=0, lcd_data=0x00, fb_rd=0, fb_addr=0, busy=1, frame_done=0.
- Reset asserted mid-transaction: all outputs take their reset values immediately and the sequence restarts at POR_LO. No partial E pulse may be extended.
- WR length is 1+2·E_CYCLES cycles. A data byte takes 2+2·E_CYCLES cycles including FETCH.
- Frame length: NUM_CHIPS·8·(2·(1+2E) + 64·(2+2E)) cycles, plus 1+2E if a disp_en update is sent.
- frame_start is sampled only in IDLE. Pulses while busy are ignored, not queued. frame_start and auto_refresh together start exactly one frame.
- busy falls on the first IDLE cycle. IDLE→FRAME SETUP takes 1 cycle after frame_start.
- fb_data is sampled exactly one cycle after fb_rd, so the framebuffer must be a synchronous-read RAM.

## Structure
- Shared package glcd_pkg:
  - command constants CMD_DISP_OFF=0x3E, CMD_DISP_ON=0x3F, CMD_START=0xC0, CMD_PAGE=0xB8, CMD_YADDR=0x40;
  - state enum;
  - PANEL_COLS=64, PANEL_PAGES=8.
- One sub-module, glcd_bus_wr. It takes a start/done handshake and runs SETUP/E_HI/E_LO with the E_CYCLES counter. The top-level FSM issues commands and data through it.

## Test plan
- Power-on with POR_CYCLES=8, E_CYCLES=2:
  - lcd_rst_n is low for 8 cycles, then high 8 cycles;
  - then two broadcast writes, lcd_data=0x3F then 0xC0, each with lcd_e high for exactly 2 cycles;
  - busy falls.
- NUM_CHIPS=2, E_CYCLES=2, framebuffer byte = address[7:0]:
  - frame_start → 16 (page, Y-addr) command pairs;
  - 1024 data writes, with chip 1 page 3 col 5 carrying 0xC5;
  - frame_done arrives 16·(10+64·6)=6304 cycles after start.
- frame_start pulsed mid-frame → ignored; exactly one frame_done.
- auto_refresh=1 → back-to-back frames; the second page-0 command SETUP is 1 cycle after frame_done.
- disp_en toggled 1→0 mid-frame → a broadcast 0x3E write after that frame's last data write, and none earlier.
- rst_n asserted during E_HI of a data write → lcd_e=0 and lcd_rst_n=0 in the same cycle; the POR sequence restarts.
